// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// Shared types for the late writeback arbiter: writeback packet layout,
// processor config selector, round-robin lock states and the starve default.
package bp_be_late_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg
    } bp_params_e;

    localparam int dword_width_gp           = 64;
    localparam int late_wb_starve_cycles_gp = 16;

    typedef struct packed {
        logic                      ird_w_v;
        logic                      frd_w_v;
        logic [4:0]                rd_addr;
        logic [dword_width_gp-1:0] rd_data;
        logic                      fflags_w_v;
        logic [4:0]                fflags;
    } bp_be_wb_pkt_s;

    typedef enum logic {
        e_rr_open,
        e_rr_locked
    } late_wb_rr_state_e;

    function automatic int wb_pkt_width(input bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_default_cfg: w = $bits(bp_be_wb_pkt_s);
            default:          w = $bits(bp_be_wb_pkt_s);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bp_be_late_wb_rr.sv
// Round-robin grant with lock: the grant is held until consumed, then the
// pointer advances past the winner and a new pick is taken from post-pop requests.
//
//  state       | meaning
//  e_rr_open   | no packet presented; pick any requester on the next edge
//  e_rr_locked | grant presented; held stable until yumi
module bp_be_late_wb_rr
    import bp_be_late_wb_arbiter_pkg::*;
#(
    parameter  int num_src_p = 2,
    localparam int id_w_lp   = $clog2(num_src_p)
)
(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_src_p-1:0] req_i,
    input  logic                 yumi_i,
    output logic                 grant_v_o,
    output logic [num_src_p-1:0] grant_oh_o,
    output logic [id_w_lp-1:0]   grant_id_o
);

    late_wb_rr_state_e    state_r, state_n;
    logic [id_w_lp-1:0]   ptr_r, ptr_n, id_r, id_n, pick_id, cand;
    logic                 pick_v;

    always_comb begin
        ptr_n = ptr_r;
        if (yumi_i)
            ptr_n = (id_r == id_w_lp'(num_src_p-1)) ? '0 : id_r + 1'b1;
    end

    // Descending scan so the requester closest to the pointer wins.
    always_comb begin
        pick_v  = 1'b0;
        pick_id = '0;
        cand    = '0;
        for (int off = num_src_p-1; off >= 0; off--) begin
            cand = id_w_lp'((int'(ptr_n) + off) % num_src_p);
            if (req_i[cand]) begin
                pick_v  = 1'b1;
                pick_id = cand;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        id_n    = id_r;
        case (state_r)
            e_rr_open: begin
                if (pick_v) begin
                    state_n = e_rr_locked;
                    id_n    = pick_id;
                end
            end
            e_rr_locked: begin
                if (yumi_i) begin
                    if (pick_v) id_n = pick_id;
                    else        state_n = e_rr_open;
                end
            end
            default: state_n = e_rr_open;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_rr_open;
            ptr_r   <= '0;
            id_r    <= '0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            id_r    <= id_n;
        end
    end

    always_comb begin
        grant_v_o        = (state_r == e_rr_locked);
        grant_id_o       = id_r;
        grant_oh_o       = '0;
        grant_oh_o[id_r] = grant_v_o;
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Merges per-source late writebacks onto one v/yumi port with round-robin arbitration.
// Optional BP_LATE_WB_STARVE_EN adds a stall counter that also raises force.
module bp_be_late_wb_arbiter
    import bp_be_late_wb_arbiter_pkg::*;
#(
    parameter  bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter  int         num_src_p       = 2,
    parameter  int         fifo_els_p      = 2,
    parameter  int         starve_cycles_p = late_wb_starve_cycles_gp,
    localparam int         wb_pkt_w_lp     = wb_pkt_width(bp_params_p)
)
(
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_src_p*wb_pkt_w_lp-1:0] src_pkt_i,
    input  logic [num_src_p-1:0]             src_v_i,
    output logic [num_src_p-1:0]             src_ready_and_o,
    output logic [wb_pkt_w_lp-1:0]           late_wb_pkt_o,
    output logic                             late_wb_v_o,
    output logic                             late_wb_force_o,
    input  logic                             late_wb_yumi_i,
    output logic                             busy_o
);

    localparam int cnt_w_lp = $clog2(fifo_els_p+1);
    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int id_w_lp  = $clog2(num_src_p);

    if (num_src_p < 2 || fifo_els_p < 2 || starve_cycles_p < 1) begin : g_bad_params
        $error("bp_be_late_wb_arbiter: illegal parameterization");
    end

    logic [num_src_p-1:0]   enq, deq, full, nonempty, req_next, grant_oh;
    logic [id_w_lp-1:0]     grant_id;
    logic                   grant_v, yumi_qual, starved;
    logic [wb_pkt_w_lp-1:0] head [num_src_p];

    // Yumi without a presented packet is ignored so state stays intact.
    assign yumi_qual = late_wb_yumi_i & grant_v;

    for (genvar s = 0; s < num_src_p; s++) begin : g_src
        logic [wb_pkt_w_lp-1:0] mem_r [fifo_els_p];
        logic [ptr_w_lp-1:0]    rptr_r, wptr_r;
        logic [cnt_w_lp-1:0]    cnt_r, cnt_n;

        assign full[s]            = (cnt_r == cnt_w_lp'(fifo_els_p));
        assign nonempty[s]        = (cnt_r != '0);
        assign src_ready_and_o[s] = reset_n_i & ~full[s];
        assign enq[s]             = src_v_i[s] & src_ready_and_o[s];
        assign deq[s]             = yumi_qual & grant_oh[s];
        assign head[s]            = mem_r[rptr_r];
        assign req_next[s]        = (cnt_n != '0);

        always_comb begin
            cnt_n = cnt_r;
            case ({enq[s], deq[s]})
                2'b10:   cnt_n = cnt_r + 1'b1;
                2'b01:   cnt_n = cnt_r - 1'b1;
                default: cnt_n = cnt_r;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (enq[s]) mem_r[wptr_r] <= src_pkt_i[s*wb_pkt_w_lp +: wb_pkt_w_lp];
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                rptr_r <= '0;
                wptr_r <= '0;
                cnt_r  <= '0;
            end else begin
                cnt_r <= cnt_n;
                if (enq[s])
                    wptr_r <= (wptr_r == ptr_w_lp'(fifo_els_p-1)) ? '0 : wptr_r + 1'b1;
                if (deq[s])
                    rptr_r <= (rptr_r == ptr_w_lp'(fifo_els_p-1)) ? '0 : rptr_r + 1'b1;
            end
        end
    end

    bp_be_late_wb_rr #(.num_src_p(num_src_p)) rr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .req_i      (req_next),
        .yumi_i     (yumi_qual),
        .grant_v_o  (grant_v),
        .grant_oh_o (grant_oh),
        .grant_id_o (grant_id)
    );

`ifdef BP_LATE_WB_STARVE_EN
    localparam int starve_w_lp = $clog2(starve_cycles_p+1);
    logic [starve_w_lp-1:0] starve_cnt_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || !grant_v || late_wb_yumi_i)
            starve_cnt_r <= '0;
        else if (starve_cnt_r != starve_w_lp'(starve_cycles_p))
            starve_cnt_r <= starve_cnt_r + 1'b1;
    end

    assign starved = (starve_cnt_r >= starve_w_lp'(starve_cycles_p));
`else
    assign starved = 1'b0;
`endif

    assign late_wb_v_o     = grant_v;
    assign late_wb_pkt_o   = head[grant_id];
    assign late_wb_force_o = grant_v & ((|full) | starved);
    assign busy_o          = |nonempty;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) assert (!(late_wb_yumi_i && !late_wb_v_o));
    end
`endif

endmodule
